// File: rtl/hazard_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and RV32 opcodes also used by the main decoder.
// Pure declarations; no timing or flow control.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_LOAD) || (op == OP_IMM) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline hazard sources in, register enables/bubbles and statistics out.
// master = pipeline side, slave = hazard controller.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_memRead;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             ex_jump;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic [1:0]       state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] memwait_cnt;

    modport master (
        output id_opcode, id_rs1, id_rs2, ex_memRead, ex_rd, ex_branch_taken,
               ex_jump, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_flush, memwb_flush, state, mem_timeout, stall_cnt,
               flush_cnt, memwait_cnt
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, ex_memRead, ex_rd, ex_branch_taken,
               ex_jump, mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_flush, memwb_flush, state, mem_timeout, stall_cnt,
               flush_cnt, memwait_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: increments by one per cycle with inc high, holds at all-ones.
// Result visible one cycle after the event; never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline; enables and bubbles are combinational (zero latency).
// A memory wait freezes the whole pipe; MEM_WAIT_MAX consecutive not-ready cycles lock it in HALT until reset.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input logic                          clk,
    input logic                          rst_n,
    pipeline_hazard_controller_if.slave  bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_timeout;

    logic w_load_use, w_mem_wait, w_flush, w_halted, w_timeout_hit;
    logic w_pc_write, w_ifid_write, w_idex_write, w_exmem_write;
    logic w_ifid_flush, w_idex_flush, w_memwb_flush;
    logic w_stall_inc, w_flush_inc, w_memwait_inc;

    assign w_load_use = bus.ex_memRead && (bus.ex_rd != 5'd0) &&
                        ((uses_rs1(bus.id_opcode) && (bus.id_rs1 == bus.ex_rd)) ||
                         (uses_rs2(bus.id_opcode) && (bus.id_rs2 == bus.ex_rd)));
    assign w_mem_wait    = bus.mem_req && !bus.mem_ready;
    assign w_flush       = bus.ex_branch_taken || bus.ex_jump;
    assign w_halted      = !rst_n || (r_state == HALT);
    // r_wait_cnt still holds the count of earlier not-ready cycles, so this cycle is number r_wait_cnt+1.
    assign w_timeout_hit = w_mem_wait && (r_wait_cnt >= WAIT_LAST);

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_write  = 1'b1;
        w_exmem_write = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_memwb_flush = 1'b0;
        if (w_halted) begin
            {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
            {w_ifid_flush, w_idex_flush, w_memwb_flush}             = 3'b111;
        end else if (w_mem_wait) begin
            {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
            w_memwb_flush = 1'b1;
        end else if (w_flush) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
        end
    end

    assign w_memwait_inc = !w_halted && w_mem_wait;
    assign w_flush_inc   = !w_halted && !w_mem_wait && w_flush;
    assign w_stall_inc   = !w_halted && !w_mem_wait && !w_flush && w_load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (r_state != HALT) begin
            if (w_mem_wait) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
                if (w_timeout_hit) begin
                    r_state   <= HALT;
                    r_timeout <= 1'b1;
                end else begin
                    r_state <= MEM_WAIT;
                end
            end else begin
                r_wait_cnt <= '0;
                r_state    <= (!w_flush && w_load_use) ? LU_STALL : RUN;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc(w_stall_inc), .cnt(bus.stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .inc(w_flush_inc), .cnt(bus.flush_cnt)
    );
    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk(clk), .rst_n(rst_n), .inc(w_memwait_inc), .cnt(bus.memwait_cnt)
    );

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.idex_write  = w_idex_write;
    assign bus.exmem_write = w_exmem_write;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.memwb_flush = w_memwb_flush;
    assign bus.state       = r_state;
    assign bus.mem_timeout = r_timeout;

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB). Each cycle it decides which pipeline registers may advance and which receive bubbles. Inputs are load-use hazards from ID, taken branches/jumps resolved in EX, and data-memory wait states in MEM. A small FSM tracks multi-cycle memory waits and a fatal timeout. Saturating counters record stall and flush statistics.

## Interface
Parameters:
- CNT_W, 16, width of each saturating performance counter
- MEM_WAIT_MAX, 15, consecutive not-ready cycles tolerated before timeout (1..255)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- id_opcode  in  7  opcode of instruction in IF/ID
- id_rs1, id_rs2  in  5 each  source registers in IF/ID
- ex_memRead  in  1  instruction in ID/EX is a load
- ex_rd  in  5  destination register in ID/EX
- ex_branch_taken  in  1  beq in EX resolved taken
- ex_jump  in  1  jal in EX
- mem_req  in  1  MEM-stage instruction has memRead or memWrite
- mem_ready  in  1  data memory completes this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register load enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  insert bubble (zero control bits)
- state  out  2  FSM state, for debug
- mem_timeout  out  1  sticky fatal error
- stall_cnt, flush_cnt, memwait_cnt  out  CNT_W each  statistics

## Operation
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, HALT=3. Control outputs are combinational from state and inputs. State, counters and timeout are registered.
- Source usage by opcode:
  - rs1 is used by 0110011, 0000011, 0010011, 0100011, 1100011.
  - rs2 is used by 0110011, 0100011, 1100011.
  - Register x0 never causes a hazard.
- load_use = ex_memRead && ex_rd!=0 && ((rs1 used && id_rs1==ex_rd) || (rs2 used && id_rs2==ex_rd)).
- Priority, highest first:
  - HALT
  - mem wait: mem_req && !mem_ready
  - flush: ex_branch_taken || ex_jump
  - load_use
  - normal
- Normal: all *_write=1, all *_flush=0.
- Mem wait:
  - All *_write=0 and memwb_flush=1.
  - Branch and load-use signals are ignored. EX is frozen, so they are re-evaluated on the exit cycle.
  - Next state is MEM_WAIT. memwait_cnt increments.
- Flush:
  - All writes=1, plus ifid_flush=1 and idex_flush=1. This kills the two younger instructions.
  - Next state is RUN. flush_cnt increments.
  - A taken branch that coincides with load_use is handled as a flush only; the stall is discarded.
- Load-use:
  - pc_write=0, ifid_write=0, idex_flush=1, others normal.
  - Next state is LU_STALL. stall_cnt increments.
- LU_STALL: evaluated exactly like RUN. The hazard has cleared because ID/EX now holds the bubble. The state exists for debug visibility and returns to RUN unless a new event occurs.
- MEM_WAIT:
  - An internal wait counter starts at 1 on entry and increments each not-ready cycle.
  - If mem_ready=1, that cycle behaves as a RUN-cycle evaluation and the wait counter clears.
  - When the wait counter reaches MEM_WAIT_MAX with mem_ready still 0, the next state is HALT and mem_timeout is set to 1.
- HALT: all writes=0 and all flushes=1. Only rst_n exits HALT.
- Counters saturate at 2^CNT_W−1; they never wrap.

## Timing
- Reset (rst_n low, asynchronous):
  - State=RUN, counters=0, mem_timeout=0, wait counter=0.
  - Outputs while held in reset: all *_write=0, all *_flush=1.
- Hazard response has zero latency: enables are valid in the same cycle the condition is present.
- Load-use costs exactly 1 bubble. A taken branch or jump costs exactly 2 bubbles.
- A memory wait of N not-ready cycles costs N stalled cycles, with N < MEM_WAIT_MAX.
- Timeout: HALT is entered on the edge after the MEM_WAIT_MAX-th consecutive not-ready cycle.
- Reset asserted mid-wait or in HALT immediately forces the reset outputs. The next rising edge after release evaluates from RUN.

## Structure
- Shared package hazard_pkg holds:
  - The state enum.
  - Opcode constants OP_R=0110011, OP_LOAD=0000011, OP_IMM=0010011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111. These are shared with the main decoder.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output cnt) is instantiated three times.

## Test plan
- Load-use: lw x5 in EX, add x6,x5,x7 in ID → one cycle with pc_write=0, ifid_write=0, idex_flush=1, state→LU_STALL, stall_cnt=1; next cycle all writes=1.
- x0 and unused rs2: lw x0 followed by add x1,x0,x0, then lw x5 followed by addi x6,x0,5 with rs2 field=5 → no stall in either case.
- Branch taken: ex_branch_taken=1 with load_use also true → ifid_flush=idex_flush=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high → 3 cycles of all writes=0 and memwb_flush=1, memwait_cnt=3, state returns to RUN, pending taken branch flushes on the exit cycle.
- Timeout: mem_ready held low with MEM_WAIT_MAX=4 → HALT after 4 cycles, mem_timeout=1, all flushes=1. Asserting rst_n low clears everything asynchronously.
- Saturation: CNT_W=2 with 5 load-use events → stall_cnt stays at 3.
